// File: rtl/pi_sample_ctrl.sv
// Monte Carlo pi-estimation run sequencer: optional pixel-memory clear sweep,
// then sample accept, inside-circle classification, pixel write and counting.
module pi_sample_ctrl #(
    parameter int SIDE        = 473,
    parameter int CENTER      = 236,
    parameter int RADIUS      = 236,
    parameter int NUM_SAMPLES = 65536,
    parameter int CNT_W       = 17,
    parameter int CLEAR_EN    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             sample_valid,
    input  logic [8:0]       sample_x,
    input  logic [8:0]       sample_y,
    output logic             sample_ready,
    output logic             wr_valid,
    output logic [8:0]       wr_x,
    output logic [8:0]       wr_y,
    output logic             wr_color,
    input  logic             wr_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] total_count,
    output logic [CNT_W-1:0] inside_count
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_SAMPLE, ST_CHECK, ST_WRITE, ST_DONE
    } state_t;

    localparam logic [9:0]        SIDE_W = 10'(SIDE);
    localparam logic [8:0]        LAST   = 9'(SIDE - 1);
    localparam logic [18:0]       R2     = 19'(RADIUS * RADIUS);
    localparam logic [CNT_W-1:0]  NUM_W  = CNT_W'(NUM_SAMPLES);
    localparam logic signed [19:0] CTR   = 20'(CENTER);

    state_t state_q, state_d;

    logic [8:0]       clr_x, clr_y, smp_x, smp_y;
    logic             inside_q;
    logic [CNT_W-1:0] total_q, inside_cnt_q, total_inc;
    logic             in_range, sample_fire, wr_fire, clr_last, last_sample;
    logic signed [19:0] dx, dy, sq_x, sq_y;
    logic [18:0]      d2;

    assign in_range    = ({1'b0, sample_x} < SIDE_W) && ({1'b0, sample_y} < SIDE_W);
    assign sample_fire = sample_ready && sample_valid && in_range;
    assign wr_fire     = wr_valid && wr_ready;
    assign clr_last    = (clr_x == LAST) && (clr_y == LAST);
    assign total_inc   = total_q + CNT_W'(1);
    assign last_sample = (total_inc == NUM_W);

    // Distances are widened to 20 bits up front; values match the 10-bit signed form.
    assign dx   = $signed({11'b0, smp_x}) - CTR;
    assign dy   = $signed({11'b0, smp_y}) - CTR;
    assign sq_x = dx * dx;
    assign sq_y = dy * dy;
    assign d2   = 19'(sq_x + sq_y);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (CLEAR_EN != 0) ? ST_CLEAR : ST_SAMPLE;
                end
            end
            ST_CLEAR: begin
                if (wr_fire && clr_last) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (sample_fire) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_WRITE;
            ST_WRITE: begin
                if (wr_fire) begin
                    state_d = last_sample ? ST_DONE : ST_SAMPLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sample_ready = 1'b0;
        wr_valid     = 1'b0;
        wr_x         = '0;
        wr_y         = '0;
        wr_color     = 1'b0;
        done         = 1'b0;
        busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
        case (state_q)
            ST_CLEAR: begin
                wr_valid = 1'b1;
                wr_x     = clr_x;
                wr_y     = clr_y;
            end
            ST_SAMPLE: sample_ready = !pause;
            ST_WRITE: begin
                wr_valid = 1'b1;
                wr_color = 1'b1;
                wr_x     = smp_x;
                wr_y     = smp_y;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_x        <= '0;
            clr_y        <= '0;
            smp_x        <= '0;
            smp_y        <= '0;
            inside_q     <= 1'b0;
            total_q      <= '0;
            inside_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        total_q      <= '0;
                        inside_cnt_q <= '0;
                        clr_x        <= '0;
                        clr_y        <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (wr_fire) begin
                        if (clr_x == LAST) begin
                            clr_x <= '0;
                            clr_y <= clr_y + 9'd1;
                        end else begin
                            clr_x <= clr_x + 9'd1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (sample_fire) begin
                        smp_x <= sample_x;
                        smp_y <= sample_y;
                    end
                end
                ST_CHECK: inside_q <= (d2 <= R2);
                ST_WRITE: begin
                    if (wr_fire) begin
                        total_q <= total_inc;
                        if (inside_q) begin
                            inside_cnt_q <= inside_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign total_count  = total_q;
    assign inside_count = inside_cnt_q;

endmodule

// File: tb/tb_pi_sample_ctrl.sv
// Bench for pi_sample_ctrl: a full-size sampling instance (NUM_SAMPLES=4, no clear)
// and a small-square instance exercising the clear sweep, each against a run model.
module tb_pi_sample_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pause = 1'b0;
    logic        sample_valid = 1'b0;
    logic        wr_ready = 1'b0;
    logic [8:0]  sample_x = '0;
    logic [8:0]  sample_y = '0;
    logic        start_v [2];
    logic        sr [2];
    logic        wv [2];
    logic        wc [2];
    logic        bz [2];
    logic        dn [2];
    logic [8:0]  wx [2];
    logic [8:0]  wy [2];
    logic [16:0] tc [2];
    logic [16:0] ic [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SIDE_G = (g == 0) ? 473 : 20;
        localparam int C_G    = (g == 0) ? 236 : 10;
        localparam int R_G    = (g == 0) ? 236 : 10;
        localparam int N_G    = (g == 0) ? 4 : 2;
        localparam int CE_G   = (g == 0) ? 0 : 1;
        localparam int N2     = SIDE_G * SIDE_G;

        pi_sample_ctrl #(
            .SIDE(SIDE_G), .CENTER(C_G), .RADIUS(R_G),
            .NUM_SAMPLES(N_G), .CNT_W(17), .CLEAR_EN(CE_G)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start_v[g]), .pause(pause),
            .sample_valid(sample_valid), .sample_x(sample_x), .sample_y(sample_y),
            .sample_ready(sr[g]), .wr_valid(wv[g]), .wr_x(wx[g]), .wr_y(wy[g]),
            .wr_color(wc[g]), .wr_ready(wr_ready), .busy(bz[g]), .done(dn[g]),
            .total_count(tc[g]), .inside_count(ic[g])
        );

        // Run model: phase 0 idle, 1 running, 2 done; clear progress is a linear pixel index.
        int m_phase = 0, m_tot = 0, m_ins = 0, m_clr = 0, m_px = 0, m_py = 0, m_age = 0;
        bit m_pend = 1'b0;

        always @(negedge clk) begin
            int e_sr, e_wv, e_wc, e_wx, e_wy, dxi, dyi;
            if (!reset_n) begin
                m_phase = 0; m_tot = 0; m_ins = 0; m_clr = 0; m_pend = 1'b0;
            end
            e_sr = 0; e_wv = 0; e_wc = 0; e_wx = 0; e_wy = 0;
            if (m_phase == 1) begin
                if (m_clr < N2) begin
                    e_wv = 1; e_wx = m_clr % SIDE_G; e_wy = m_clr / SIDE_G;
                end else if (m_pend && m_age == 2) begin
                    e_wv = 1; e_wc = 1; e_wx = m_px; e_wy = m_py;
                end else if (!m_pend) begin
                    e_sr = pause ? 0 : 1;
                end
            end
            check($sformatf("dut%0d sample_ready", g), int'(sr[g]), e_sr);
            check($sformatf("dut%0d wr_valid", g), int'(wv[g]), e_wv);
            check($sformatf("dut%0d wr_color", g), int'(wc[g]), e_wc);
            check($sformatf("dut%0d wr_x", g), int'(wx[g]), e_wx);
            check($sformatf("dut%0d wr_y", g), int'(wy[g]), e_wy);
            check($sformatf("dut%0d busy", g), int'(bz[g]), (m_phase == 1) ? 1 : 0);
            check($sformatf("dut%0d done", g), int'(dn[g]), (m_phase == 2) ? 1 : 0);
            check($sformatf("dut%0d total_count", g), int'(tc[g]), m_tot);
            check($sformatf("dut%0d inside_count", g), int'(ic[g]), m_ins);
            if (reset_n) begin
                if (m_phase != 1) begin
                    if (start_v[g]) begin
                        m_phase = 1; m_tot = 0; m_ins = 0; m_pend = 1'b0;
                        m_clr = (CE_G != 0) ? 0 : N2;
                    end
                end else if (m_clr < N2) begin
                    if (wr_ready) m_clr++;
                end else if (m_pend && m_age == 1) begin
                    m_age = 2;
                end else if (m_pend) begin
                    if (wr_ready) begin
                        dxi = m_px - C_G;
                        dyi = m_py - C_G;
                        m_tot++;
                        if (dxi * dxi + dyi * dyi <= R_G * R_G) m_ins++;
                        m_pend = 1'b0;
                        if (m_tot == N_G) m_phase = 2;
                    end
                end else if (sample_valid && !pause &&
                             int'(sample_x) < SIDE_G && int'(sample_y) < SIDE_G) begin
                    m_pend = 1'b1; m_age = 1;
                    m_px = int'(sample_x); m_py = int'(sample_y);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic pulse_start(input int g);
        @(posedge clk); #1;
        start_v[g] = 1'b1;
        @(posedge clk); #1;
        start_v[g] = 1'b0;
    endtask

    task automatic send(input int g, input int x, input int y);
        bit ok;
        ok = 1'b0;
        sample_valid = 1'b1;
        sample_x = 9'(x);
        sample_y = 9'(y);
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (sr[g]) ok = 1'b1;
        end
        check("send accept timeout", int'(ok), 1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_write(input int g, input int exp_lat);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (wv[g] && wr_ready) lat = c;
        end
        check("accept-to-write latency", lat, exp_lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int nw, lx, ly;
        bit got_sr;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("reset total_count", int'(tc[0]), 0);
        check("reset busy", int'(bz[1]), 0);

        // Reset in the middle of a clear sweep
        wr_ready = 1'b1;
        pulse_start(1);
        repeat (30) @(posedge clk);
        #1 check("clearing before reset", int'(wv[1]), 1);
        reset_n = 1'b0;
        #1;
        check("async reset wr_valid", int'(wv[1]), 0);
        check("async reset wr_x", int'(wx[1]), 0);
        check("async reset busy", int'(bz[1]), 0);
        check("async reset sample_ready", int'(sr[1]), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no write after reset", int'(wv[1]), 0);
        end

        // Full clear sweep of a 20x20 square
        pulse_start(1);
        nw = 0; lx = -1; ly = -1; got_sr = 1'b0;
        for (int c = 0; c < 1000 && !got_sr; c++) begin
            @(negedge clk);
            if (wv[1]) begin
                nw++;
                if (nw == 1) begin
                    check("first clear x", int'(wx[1]), 0);
                    check("first clear y", int'(wy[1]), 0);
                end
                if (nw == 21) begin
                    check("clear 21 x", int'(wx[1]), 0);
                    check("clear 21 y", int'(wy[1]), 1);
                end
                lx = int'(wx[1]);
                ly = int'(wy[1]);
            end else if (sr[1]) begin
                got_sr = 1'b1;
            end
        end
        check("clear write count", nw, 400);
        check("last clear x", lx, 19);
        check("last clear y", ly, 19);
        check("sample_ready after clear", int'(got_sr), 1);
        do_reset();

        // Classification on the full-size geometry
        pulse_start(0);
        send(0, 236, 236); wait_write(0, 2);
        send(0, 236, 0);   wait_write(0, 2);
        send(0, 0, 0);     wait_write(0, 2);
        check("total after three", int'(tc[0]), 3);
        check("inside after three", int'(ic[0]), 2);

        // Pause blocks acceptance
        pause = 1'b1;
        sample_valid = 1'b1;
        sample_x = 9'd100;
        sample_y = 9'd100;
        repeat (3) begin
            @(negedge clk);
            check("paused sample_ready", int'(sr[0]), 0);
            check("paused wr_valid", int'(wv[0]), 0);
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        pause = 1'b0;

        // Out-of-range sample is dropped
        sample_valid = 1'b1;
        sample_x = 9'd480;
        sample_y = 9'd10;
        repeat (3) begin
            @(negedge clk);
            check("out of range ready", int'(sr[0]), 1);
            check("out of range no write", int'(wv[0]), 0);
            check("out of range total", int'(tc[0]), 3);
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;

        // Backpressure on the final sample, with an ignored mid-run start
        wr_ready = 1'b0;
        send(0, 10, 10);
        got_sr = 1'b0;
        for (int c = 0; c < 10 && !got_sr; c++) begin
            @(negedge clk);
            if (wv[0]) got_sr = 1'b1;
        end
        check("backpressure write seen", int'(got_sr), 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stalled wr_x", int'(wx[0]), 10);
            check("stalled wr_y", int'(wy[0]), 10);
            check("stalled wr_color", int'(wc[0]), 1);
            check("stalled total", int'(tc[0]), 3);
            @(posedge clk); #1;
            start_v[0] = (i == 1);
        end
        wr_ready = 1'b1;
        @(posedge clk); #1;
        check("final total", int'(tc[0]), 4);
        check("final inside", int'(ic[0]), 2);
        check("done after last", int'(dn[0]), 1);
        check("busy after last", int'(bz[0]), 0);
        repeat (3) @(negedge clk);
        check("done held", int'(dn[0]), 1);

        // Start from DONE clears the run
        pulse_start(0);
        check("restart total", int'(tc[0]), 0);
        check("restart inside", int'(ic[0]), 0);
        check("restart done", int'(dn[0]), 0);
        check("restart busy", int'(bz[0]), 1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
